// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit register-file/ALU datapath.
// Fetches 16-bit words from synchronous imem and runs each in FETCH/DECODE/EXEC.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  imem_addr,
    output logic        imem_en,
    input  logic [15:0] imem_data,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic [3:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        write_en,
    output logic        busy,
    output logic        halted
);

    // state    | meaning
    // S_IDLE   | waiting for start after reset
    // S_FETCH  | imem read of word at PC
    // S_DECODE | imem word captured into IR
    // S_EXEC   | IR drives datapath, PC advances
    // S_HALT   | stopped on HALT, PC at the HALT word
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_BRZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_c_q, flag_c_d;

    logic [3:0] ir_op;
    logic [3:0] ir_rd;
    logic [3:0] ir_ra;
    logic [3:0] ir_rb;
    logic [7:0] ir_imm;
    logic       ir_is_alu;

    assign ir_op     = ir_q[15:12];
    assign ir_rd     = ir_q[11:8];
    assign ir_ra     = ir_q[7:4];
    assign ir_rb     = ir_q[3:0];
    assign ir_imm    = ir_q[7:0];
    assign ir_is_alu = (ir_op < OP_LDI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= 8'h00;
            ir_q     <= 16'h0000;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = 8'h00;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 8'd1;
                if (ir_is_alu) begin
                    flag_z_d = alu_zero;
                    flag_c_d = alu_carry;
                end
                case (ir_op)
                    OP_JMP: pc_d = ir_imm;
                    OP_BRZ: begin
                        if (flag_z_q) begin
                            pc_d = ir_imm;
                        end
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = 8'h00;
                    flag_z_d = 1'b0;
                    flag_c_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath controls are decoded purely from state and IR, so an async
    // reset during EXEC removes write_en before the next edge.
    always_comb begin
        imem_addr  = pc_q;
        imem_en    = (state_q == S_FETCH);
        busy       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
        halted     = (state_q == S_HALT);
        alu_opcode = 4'h0;
        ra_addr    = 4'h0;
        rb_addr    = 4'h0;
        write_addr = 4'h0;
        write_data = 8'h00;
        write_en   = 1'b0;
        if (state_q == S_EXEC) begin
            if (ir_is_alu) begin
                alu_opcode = ir_op;
                ra_addr    = ir_ra;
                rb_addr    = ir_rb;
                write_addr = ir_rd;
                write_data = alu_result;
                write_en   = 1'b1;
            end else if (ir_op == OP_LDI) begin
                write_addr = ir_rd;
                write_data = ir_imm;
                write_en   = 1'b1;
            end
        end
    end

endmodule
